// File: rtl/ram_sweep_if.sv
// ram_sweep access bus: address/data/write-enable plus read handshake
// and clear-sweep status.
interface ram_sweep_if #(
  parameter int addr_width = 4,
  parameter int data_width = 4
);
  logic                  we;
  logic                  re;
  logic                  clear;
  logic [addr_width-1:0] addr;
  logic [data_width-1:0] data_in;
  logic [data_width-1:0] data_out;
  logic                  rd_valid;
  logic                  busy;

  modport master (
    output we, re, clear, addr, data_in,
    input  data_out, rd_valid, busy
  );

  modport slave (
    input  we, re, clear, addr, data_in,
    output data_out, rd_valid, busy
  );
endinterface

// File: rtl/ram_sweep.sv
// Single-port sync RAM, registered read, selectable read-during-write,
// with a clear sequencer sweeping every word after reset or on request.
module ram_sweep #(
  parameter int addr_width = 4,
  parameter int data_width = 4,
  parameter int read_mode  = 0,
  parameter logic [data_width-1:0] clear_value = '0
) (
  input logic         clk,
  input logic         rst_n,
  ram_sweep_if.slave  bus
);

  localparam logic [0:0] SWEEP = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;
  localparam int         DEPTH = 2 ** addr_width;

  logic [0:0]            state;
  logic [addr_width-1:0] cnt;
  logic [data_width-1:0] mem [DEPTH];
  logic [data_width-1:0] rd_data;
  logic [data_width-1:0] dout_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  acc;
  logic                  last;

  assign acc  = (state == IDLE) && !bus.clear;
  assign last = (cnt == {addr_width{1'b1}});

  // write-first bypasses the array with the incoming word
  always_comb begin
    rd_data = mem[bus.addr];
    if (bus.we && read_mode == 0) rd_data = bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == SWEEP)
        mem[cnt] <= clear_value;
      else if (acc && bus.we)
        mem[bus.addr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= SWEEP;
      cnt     <= '0;
      busy_q  <= 1'b1;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        SWEEP: begin
          valid_q <= 1'b0;
          cnt     <= cnt + 1'b1;
          if (last) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        IDLE: begin
          if (bus.clear) begin
            state   <= SWEEP;
            cnt     <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
          end else begin
            valid_q <= bus.re;
            if (bus.re) dout_q <= rd_data;
          end
        end
        default: state <= SWEEP;
      endcase
    end
  end

  assign bus.data_out = dout_q;
  assign bus.rd_valid = valid_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_ram_sweep.sv
// Directed bench: write-first/clear 0 and read-first/clear 6 copies share
// one stimulus table; a 64x8 copy gets a hand sequence.
module tb_ram_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       we, re, clr;
  logic [3:0] addr, din;

  logic       rst_c;
  logic       cwe, cre, cclr;
  logic [5:0] caddr;
  logic [7:0] cdin;

  ram_sweep_if #(.addr_width(4), .data_width(4)) ifa ();
  ram_sweep_if #(.addr_width(4), .data_width(4)) ifb ();
  ram_sweep_if #(.addr_width(6), .data_width(8)) ifc ();

  assign ifa.we = we;
  assign ifa.re = re;
  assign ifa.clear = clr;
  assign ifa.addr = addr;
  assign ifa.data_in = din;
  assign ifb.we = we;
  assign ifb.re = re;
  assign ifb.clear = clr;
  assign ifb.addr = addr;
  assign ifb.data_in = din;
  assign ifc.we = cwe;
  assign ifc.re = cre;
  assign ifc.clear = cclr;
  assign ifc.addr = caddr;
  assign ifc.data_in = cdin;

  ram_sweep #(
    .addr_width(4), .data_width(4),
    .read_mode(0), .clear_value(4'h0)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

  ram_sweep #(
    .addr_width(4), .data_width(4),
    .read_mode(1), .clear_value(4'h6)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  ram_sweep #(
    .addr_width(6), .data_width(8),
    .read_mode(0), .clear_value(8'h3C)
  ) dut_c (.clk(clk), .rst_n(rst_c), .bus(ifc));

  typedef struct {
    logic       rst_n;
    logic       we;
    logic       re;
    logic       clr;
    logic [3:0] addr;
    logic [3:0] din;
    logic       rv;
    logic       busy;
    logic [3:0] qa;
    logic [3:0] qb;
    string      name;
  } vec_t;

  vec_t vt[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    logic r, logic w, logic rd, logic c,
    logic [3:0] a, logic [3:0] d,
    logic rv, logic b, logic [3:0] qa, logic [3:0] qb,
    string nm
  );
    vec_t x;
    x.rst_n = r; x.we = w; x.re = rd; x.clr = c;
    x.addr = a; x.din = d; x.rv = rv; x.busy = b;
    x.qa = qa; x.qb = qb; x.name = nm;
    return x;
  endfunction

  // 16 edges of a sweep with re/we hammering; outputs must hold
  task automatic push_sweep(int n, logic [3:0] qa, logic [3:0] qb);
    for (int i = 1; i <= n; i++)
      vt.push_back(mk(1, 1, 1, 0, 4'h2, 4'hD, 0, i < 16, qa, qb,
                      $sformatf("sweep%0d", i)));
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; we = 0; re = 0; clr = 0; addr = '0; din = '0;
    rst_c = 0; cwe = 0; cre = 0; cclr = 0; caddr = '0; cdin = '0;

    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h0, "reset"));
    push_sweep(16, 4'h0, 4'h0);
    for (int i = 0; i < 16; i++)
      vt.push_back(mk(1, 0, 1, 0, 4'(i), 0, 1, 0, 4'h0, 4'h6,
                      $sformatf("rd_clr%0d", i)));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h6, "rv_drop"));
    vt.push_back(mk(1, 1, 0, 0, 3, 4'hA, 0, 0, 4'h0, 4'h6, "wr3"));
    vt.push_back(mk(1, 1, 0, 0, 12, 4'h5, 0, 0, 4'h0, 4'h6, "wr12"));
    vt.push_back(mk(1, 0, 1, 0, 3, 0, 1, 0, 4'hA, 4'hA, "rd3"));
    vt.push_back(mk(1, 0, 1, 0, 12, 0, 1, 0, 4'h5, 4'h5, "rd12"));
    vt.push_back(mk(1, 0, 1, 0, 4, 0, 1, 0, 4'h0, 4'h6, "rd4"));
    vt.push_back(mk(1, 1, 0, 0, 7, 4'h2, 0, 0, 4'h0, 4'h6, "wr7"));
    vt.push_back(mk(1, 1, 1, 0, 7, 4'h9, 1, 0, 4'h9, 4'h2, "rdw7"));
    vt.push_back(mk(1, 0, 1, 0, 7, 0, 1, 0, 4'h9, 4'h9, "rd7"));
    vt.push_back(mk(1, 1, 1, 1, 1, 4'hF, 0, 1, 4'h9, 4'h9, "clr_wr"));
    push_sweep(16, 4'h9, 4'h9);
    vt.push_back(mk(1, 0, 1, 0, 1, 0, 1, 0, 4'h0, 4'h6, "rd1"));
    vt.push_back(mk(1, 0, 1, 0, 3, 0, 1, 0, 4'h0, 4'h6, "rd3c"));
    vt.push_back(mk(1, 0, 1, 0, 2, 0, 1, 0, 4'h0, 4'h6, "rd2"));
    vt.push_back(mk(1, 1, 0, 0, 5, 4'hB, 0, 0, 4'h0, 4'h6, "wr5"));
    vt.push_back(mk(1, 0, 1, 0, 5, 0, 1, 0, 4'hB, 4'hB, "rd5"));
    vt.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 4'hB, 4'hB, "clr2"));
    for (int i = 1; i <= 4; i++)
      vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 4'hB, 4'hB,
                      $sformatf("part%0d", i)));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h0, "mid_rst"));
    push_sweep(16, 4'h0, 4'h0);
    vt.push_back(mk(1, 0, 1, 0, 5, 0, 1, 0, 4'h0, 4'h6, "rd5c"));
    vt.push_back(mk(1, 0, 1, 0, 15, 0, 1, 0, 4'h0, 4'h6, "rd15"));

    for (int i = 0; i < vt.size(); i++) begin
      rst_n = vt[i].rst_n;
      we    = vt[i].we;
      re    = vt[i].re;
      clr   = vt[i].clr;
      addr  = vt[i].addr;
      din   = vt[i].din;
      step();
      chk({vt[i].name, ".a.rv"}, 8'(ifa.rd_valid), 8'(vt[i].rv));
      chk({vt[i].name, ".b.rv"}, 8'(ifb.rd_valid), 8'(vt[i].rv));
      chk({vt[i].name, ".a.busy"}, 8'(ifa.busy), 8'(vt[i].busy));
      chk({vt[i].name, ".b.busy"}, 8'(ifb.busy), 8'(vt[i].busy));
      chk({vt[i].name, ".a.q"}, 8'(ifa.data_out), 8'(vt[i].qa));
      chk({vt[i].name, ".b.q"}, 8'(ifb.data_out), 8'(vt[i].qb));
    end
    rst_n = 1; we = 0; re = 0;

    // 64x8 instance: reset, 64-edge sweep with ignored traffic, accesses
    step();
    chk("c.rst.busy", 8'(ifc.busy), 8'h1);
    chk("c.rst.q", ifc.data_out, 8'h00);
    rst_c = 1; cwe = 1; cre = 1; caddr = 6'd10; cdin = 8'h77;
    for (int i = 1; i <= 64; i++) begin
      step();
      chk($sformatf("c.sweep%0d.busy", i), 8'(ifc.busy), 8'(i < 64));
      chk($sformatf("c.sweep%0d.rv", i), 8'(ifc.rd_valid), 8'h0);
    end
    chk("c.sweep.q", ifc.data_out, 8'h00);
    cwe = 0; cre = 1; caddr = 6'd10;
    step();
    chk("c.rd10.rv", 8'(ifc.rd_valid), 8'h1);
    chk("c.rd10.q", ifc.data_out, 8'h3C);
    cwe = 1; cre = 0; caddr = 6'd63; cdin = 8'hA5;
    step();
    chk("c.wr63.rv", 8'(ifc.rd_valid), 8'h0);
    cwe = 0; cre = 1;
    step();
    chk("c.rd63.q", ifc.data_out, 8'hA5);
    cwe = 1; cre = 1; cdin = 8'h5A;
    step();
    chk("c.rdw63.q", ifc.data_out, 8'h5A);
    cwe = 0; caddr = 6'd0;
    step();
    chk("c.rd0.q", ifc.data_out, 8'h3C);
    caddr = 6'd63;
    step();
    chk("c.rd63b.q", ifc.data_out, 8'h5A);
    cre = 0;
    step();
    chk("c.idle.rv", 8'(ifc.rd_valid), 8'h0);
    chk("c.idle.q", ifc.data_out, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
